// File: rtl/banked_phys_register_file.sv
// Banked physical register file: one bank per writeback group, in-use tracking,
// a self-timed zeroing sweep, and registered issue-stage operands with late-writeback refresh.
module banked_phys_register_file #(
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 64,
    parameter int READ_PORTS    = 2,
    parameter int NUM_WB_GROUPS = 2,
    parameter int USE_ZERO      = 0,
    localparam int AW = $clog2(DEPTH),
    localparam int GW = (NUM_WB_GROUPS > 1) ? $clog2(NUM_WB_GROUPS) : 1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      init_clear,
    output logic                                      init_done,
    input  logic                                      alloc_valid,
    input  logic [AW-1:0]                             alloc_addr,
    input  logic                                      rd_advance,
    input  logic [READ_PORTS-1:0][AW-1:0]             rd_addr,
    input  logic [READ_PORTS-1:0][GW-1:0]             rd_group,
    output logic [READ_PORTS-1:0][DATA_WIDTH-1:0]     rs_data,
    output logic [READ_PORTS-1:0]                     rs_inuse,
    input  logic [NUM_WB_GROUPS-1:0]                  wb_valid,
    input  logic [NUM_WB_GROUPS-1:0][AW-1:0]          wb_addr,
    input  logic [NUM_WB_GROUPS-1:0][DATA_WIDTH-1:0]  wb_data,
    input  logic                                      wb_suppress
);

    typedef enum logic {SWEEP, READY} state_t;

    state_t                                  state_q, state_d;
    logic [AW-1:0]                           cnt_q, cnt_d;
    logic [NUM_WB_GROUPS-1:0]                wr_eff;
    logic                                    alloc_eff;
    logic                                    multi_hit;
    logic [DEPTH-1:0]                        inuse_q;
    logic [DATA_WIDTH-1:0]                   bank [NUM_WB_GROUPS][DEPTH];
    logic [READ_PORTS-1:0][DATA_WIDTH-1:0]   dec_data;
    logic [READ_PORTS-1:0][AW-1:0]           iss_addr;
    logic [READ_PORTS-1:0][GW-1:0]           iss_group;

    assign init_done = (state_q == READY);

    always_comb begin
        alloc_eff = alloc_valid & init_done & ((USE_ZERO != 0) | (alloc_addr != '0));
        for (int unsigned g = 0; g < NUM_WB_GROUPS; g++) begin
            wr_eff[g] = wb_valid[g] & ~wb_suppress & init_done &
                        ((USE_ZERO != 0) | (wb_addr[g] != '0));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            SWEEP: begin
                if (init_clear) begin
                    cnt_d = '0;
                end else if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            READY: begin
                if (init_clear) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = SWEEP;
                cnt_d   = '0;
            end
        endcase
    end

    // Storage is not reset; the sweep defines its contents.
    always_ff @(posedge clk) begin
        for (int unsigned g = 0; g < NUM_WB_GROUPS; g++) begin
            if (state_q == SWEEP) begin
                bank[g][cnt_q] <= '0;
            end else if (wr_eff[g]) begin
                bank[g][wb_addr[g]] <= wb_data[g];
            end
        end
    end

    // The alloc set is scheduled after the clears so it wins on a collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inuse_q <= '0;
        end else if (state_q == SWEEP) begin
            inuse_q[cnt_q] <= 1'b0;
        end else begin
            for (int unsigned g = 0; g < NUM_WB_GROUPS; g++) begin
                if (wr_eff[g]) inuse_q[wb_addr[g]] <= 1'b0;
            end
            if (alloc_eff) inuse_q[alloc_addr] <= 1'b1;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < READ_PORTS; i++) begin
            dec_data[i] = '0;
            if ((USE_ZERO != 0) || (rd_addr[i] != '0)) begin
                if (32'(rd_group[i]) < NUM_WB_GROUPS) begin
                    dec_data[i] = bank[rd_group[i]][rd_addr[i]];
                end
                for (int unsigned g = 0; g < NUM_WB_GROUPS; g++) begin
                    if (wr_eff[g] && (GW'(g) == rd_group[i]) && (wb_addr[g] == rd_addr[i])) begin
                        dec_data[i] = wb_data[g];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_addr  <= '0;
            iss_group <= '0;
            rs_data   <= '0;
        end else if (init_done) begin
            for (int unsigned i = 0; i < READ_PORTS; i++) begin
                if (rd_advance) begin
                    iss_addr[i]  <= rd_addr[i];
                    iss_group[i] <= rd_group[i];
                    rs_data[i]   <= dec_data[i];
                end else begin
                    for (int unsigned g = 0; g < NUM_WB_GROUPS; g++) begin
                        if (wr_eff[g] && (GW'(g) == iss_group[i]) && (wb_addr[g] == iss_addr[i])) begin
                            rs_data[i] <= wb_data[g];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < READ_PORTS; i++) begin
            rs_inuse[i] = inuse_q[iss_addr[i]];
        end
    end

    always_comb begin
        multi_hit = 1'b0;
        for (int unsigned a = 0; a < NUM_WB_GROUPS; a++) begin
            for (int unsigned b = a + 1; b < NUM_WB_GROUPS; b++) begin
                if (wr_eff[a] && wr_eff[b] && (wb_addr[a] == wb_addr[b])) multi_hit = 1'b1;
            end
        end
    end

    a_single_writer: assert property (@(posedge clk) disable iff (rst) !multi_hit);

endmodule

// File: tb/tb_banked_phys_register_file.sv
// Bench for banked_phys_register_file (DEPTH=8, 2 read ports, 2 groups, hardwired zero):
// vector table through a scoreboard queue, plus hand-written init-sweep sequences.
module tb_banked_phys_register_file;

    localparam int DW = 32;
    localparam int DEPTH = 8;
    localparam int RP = 2;
    localparam int NG = 2;
    localparam int AW = 3;
    localparam int GW = 1;

    logic                       clk;
    logic                       rst;
    logic                       init_clear;
    logic                       init_done;
    logic                       alloc_valid;
    logic [AW-1:0]              alloc_addr;
    logic                       rd_advance;
    logic [RP-1:0][AW-1:0]      rd_addr;
    logic [RP-1:0][GW-1:0]      rd_group;
    logic [RP-1:0][DW-1:0]      rs_data;
    logic [RP-1:0]              rs_inuse;
    logic [NG-1:0]              wb_valid;
    logic [NG-1:0][AW-1:0]      wb_addr;
    logic [NG-1:0][DW-1:0]      wb_data;
    logic                       wb_suppress;

    banked_phys_register_file #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .READ_PORTS(RP), .NUM_WB_GROUPS(NG), .USE_ZERO(0)
    ) dut (
        .clk(clk), .rst(rst), .init_clear(init_clear), .init_done(init_done),
        .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .rd_advance(rd_advance),
        .rd_addr(rd_addr), .rd_group(rd_group), .rs_data(rs_data), .rs_inuse(rs_inuse),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_suppress(wb_suppress)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        al;
        logic [2:0]  aa;
        logic [1:0]  wv;
        logic [2:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic        sup;
        logic        adv;
        logic [2:0]  ra0, ra1;
        logic        rg0, rg1;
        logic [31:0] e0, e1;
        logic [1:0]  ei;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] e0, e1;
        logic [1:0]  ei;
    } exp_t;

    int          checks = 0;
    int          failures = 0;
    exp_t        sb[$];
    logic [1:0]  last_inuse = 2'b00;
    vec_t        vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [31:0] al, input logic [31:0] aa,
                                input logic [31:0] wv, input logic [31:0] wa0, input logic [31:0] wd0,
                                input logic [31:0] wa1, input logic [31:0] wd1, input logic [31:0] sup,
                                input logic [31:0] adv, input logic [31:0] ra0, input logic [31:0] rg0,
                                input logic [31:0] ra1, input logic [31:0] rg1,
                                input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] ei);
        vec_t v;
        v.name = n;   v.al = al[0];   v.aa = aa[2:0]; v.wv = wv[1:0];
        v.wa0 = wa0[2:0]; v.wd0 = wd0; v.wa1 = wa1[2:0]; v.wd1 = wd1;
        v.sup = sup[0]; v.adv = adv[0];
        v.ra0 = ra0[2:0]; v.rg0 = rg0[0]; v.ra1 = ra1[2:0]; v.rg1 = rg1[0];
        v.e0 = e0; v.e1 = e1; v.ei = ei[1:0];
        return v;
    endfunction

    task automatic idle();
        init_clear = 1'b0; alloc_valid = 1'b0; alloc_addr = '0; rd_advance = 1'b0;
        rd_addr = '0; rd_group = '0; wb_valid = '0; wb_addr = '0; wb_data = '0; wb_suppress = 1'b0;
    endtask

    task automatic pop_check();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.name, "_d0"}, rs_data[0], e.e0);
            chk({e.name, "_d1"}, rs_data[1], e.e1);
            chk({e.name, "_inuse"}, 32'(rs_inuse), 32'(e.ei));
            last_inuse = e.ei;
        end
    endtask

    // Drives one cycle of stimulus; rs_inuse must not move before the edge.
    task automatic drive_vec(input vec_t v);
        exp_t e;
        alloc_valid = v.al;  alloc_addr = v.aa;
        wb_valid = v.wv; wb_addr[0] = v.wa0; wb_data[0] = v.wd0;
        wb_addr[1] = v.wa1; wb_data[1] = v.wd1; wb_suppress = v.sup;
        rd_advance = v.adv; rd_addr[0] = v.ra0; rd_group[0] = v.rg0;
        rd_addr[1] = v.ra1; rd_group[1] = v.rg1;
        e.name = v.name; e.e0 = v.e0; e.e1 = v.e1; e.ei = v.ei;
        sb.push_back(e);
        #1;
        chk({v.name, "_pre_inuse"}, 32'(rs_inuse), 32'(last_inuse));
        @(posedge clk); #1;
        idle();
        pop_check();
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            drive_vec(mk($sformatf("%s_a%0d", tag, a), 0, 0, 0, 0, 0, 0, 0, 0,
                         1, a, 0, a, 1, 0, 0, 0));
        end
    endtask

    task automatic wait_ready(input string name, input int exp_cycles);
        int n = 0;
        while (!init_done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, 32'(n), 32'(exp_cycles));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            name            al aa wv  wa0 wd0           wa1 wd1           sup adv ra0 rg0 ra1 rg1 e0            e1            ei
        vecs[0]  = mk("zero_read",    0, 0, 0,  0,  0,            0,  0,            0,  1,  1,  0,  2,  1,  0,            0,            0);
        vecs[1]  = mk("alloc5",       1, 5, 0,  0,  0,            0,  0,            0,  1,  5,  1,  6,  0,  0,            0,            1);
        vecs[2]  = mk("wb5_refresh",  0, 0, 2,  0,  0,            5,  32'hDEADBEEF, 0,  0,  0,  0,  0,  0,  32'hDEADBEEF, 0,            0);
        vecs[3]  = mk("bypass3",      0, 0, 1,  3,  32'h1234,     0,  0,            0,  1,  3,  0,  5,  1,  32'h1234,     32'hDEADBEEF, 0);
        vecs[4]  = mk("alloc7",       1, 7, 0,  0,  0,            0,  0,            0,  1,  7,  1,  7,  0,  0,            0,            3);
        vecs[5]  = mk("hold7",        0, 0, 0,  0,  0,            0,  0,            0,  0,  0,  0,  0,  0,  0,            0,            3);
        vecs[6]  = mk("wb7_g1",       0, 0, 2,  0,  0,            7,  32'hA5A5A5A5, 0,  0,  0,  0,  0,  0,  32'hA5A5A5A5, 0,            0);
        vecs[7]  = mk("wb7_g0",       0, 0, 1,  7,  32'h77,       0,  0,            0,  0,  0,  0,  0,  0,  32'hA5A5A5A5, 32'h77,       0);
        vecs[8]  = mk("zero_addr",    1, 0, 1,  0,  32'hFFFF,     0,  0,            0,  1,  0,  0,  0,  1,  0,            0,            0);
        vecs[9]  = mk("alloc4",       1, 4, 0,  0,  0,            0,  0,            0,  1,  4,  0,  4,  1,  0,            0,            3);
        vecs[10] = mk("suppress4",    0, 0, 1,  4,  32'h4444,     0,  0,            1,  0,  0,  0,  0,  0,  0,            0,            3);
        vecs[11] = mk("read4_3",      0, 0, 0,  0,  0,            0,  0,            0,  1,  4,  0,  3,  0,  0,            32'h1234,     1);
        vecs[12] = mk("dual_wb",      0, 0, 3,  2,  32'h22,       6,  32'h66,       0,  0,  0,  0,  0,  0,  0,            32'h1234,     1);
        vecs[13] = mk("read2_6",      0, 0, 0,  0,  0,            0,  0,            0,  1,  2,  0,  6,  1,  32'h22,       32'h66,       0);

        idle();
        rst = 1'b1;
        #2;
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_rs_data0", rs_data[0], 32'd0);
        chk("rst_rs_inuse", 32'(rs_inuse), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wait_ready("reset_latency", DEPTH);
        read_all("post_reset");

        for (int i = 0; i < 14; i++) drive_vec(vecs[i]);

        // READY -> SWEEP on a pulse; then restart the sweep once cnt has reached 5.
        init_clear = 1'b1;
        @(posedge clk); #1;
        init_clear = 1'b0;
        chk("clear_drop", 32'(init_done), 32'd0);
        rd_advance = 1'b1; rd_addr = '0;
        repeat (5) @(posedge clk);
        #1;
        rd_advance = 1'b0;
        chk("sweep_hold_d0", rs_data[0], 32'h22);
        chk("sweep_hold_d1", rs_data[1], 32'h66);
        init_clear = 1'b1;
        @(posedge clk); #1;
        init_clear = 1'b0;
        wait_ready("restart_latency", DEPTH);
        chk("sweep_inuse", 32'(rs_inuse), 32'd0);
        last_inuse = 2'b00;
        drive_vec(mk("swept4_2", 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 2, 0, 0, 0, 0));
        read_all("post_sweep");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
